// File: rtl/ps2_pkg.sv
// ============================================================
// Module  : ps2_pkg
// Brief   : Shared types and scan-code constants for the PS/2 key scanner.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_A    = 3'd1,
    DIR_D    = 3'd2,
    DIR_W    = 3'd3,
    DIR_S    = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  function automatic dir_t wasd_dir(input logic [7:0] code);
    case (code)
      SC_A:    return DIR_A;
      SC_D:    return DIR_D;
      SC_W:    return DIR_W;
      SC_S:    return DIR_S;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================
// Module  : ps2_frame_rx
// Brief   : PS/2 line synchroniser, falling-edge detect and 11-bit frame receiver.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  rx_state_t              r_state, w_state_nxt;
  logic [2:0]             r_bit_cnt, w_bit_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic                   r_par, w_par_nxt;
  logic [TW-1:0]          r_to_cnt, w_to_nxt;
  logic                   r_bv, r_pe, r_fe;
  logic                   w_bv, w_pe, w_fe;
  logic                   w_clk_s, w_data, w_fall;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_data  = r_data_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_to_nxt    = '0;
    w_bv        = 1'b0;
    w_pe        = 1'b0;
    w_fe        = 1'b0;
    if (r_state != RX_IDLE) w_to_nxt = w_fall ? '0 : r_to_cnt + 1'b1;
    case (r_state)
      RX_IDLE: begin
        if (w_fall && !w_data) begin
          w_state_nxt = RX_DATA;
          w_bit_nxt   = '0;
        end
      end
      RX_DATA: begin
        if (w_fall) begin
          w_shift_nxt = {w_data, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (w_fall) begin
          w_par_nxt   = w_data;
          w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_fall) begin
          w_state_nxt = RX_IDLE;
          if (!w_data)                w_fe = 1'b1;
          else if (!(^r_shift ^ r_par)) w_pe = 1'b1;
          else                        w_bv = 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
    // A stalled keyboard clock abandons the partial frame
    if (r_state != RX_IDLE && !w_fall && r_to_cnt == c_TO_LAST) begin
      w_state_nxt = RX_IDLE;
      w_to_nxt    = '0;
      w_fe        = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
      r_state     <= RX_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_bv        <= 1'b0;
      r_pe        <= 1'b0;
      r_fe        <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_par       <= w_par_nxt;
      r_to_cnt    <= w_to_nxt;
      r_bv        <= w_bv;
      r_pe        <= w_pe;
      r_fe        <= w_fe;
    end
  end

  assign rx_byte    = r_shift;
  assign byte_valid = r_bv;
  assign parity_err = r_pe;
  assign frame_err  = r_fe;

endmodule

`default_nettype wire

// File: rtl/ps2_keyscan.sv
// ============================================================
// Module  : ps2_keyscan
// Brief   : PS/2 receiver, make/break/extended composer, event FIFO, WASD tracker.
// Config  : PS2_KEYSCAN_TYPEMATIC_FILTER_EN suppresses repeated makes.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

module ps2_keyscan
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [2:0] dir,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW + 1)'(FIFO_DEPTH);

  logic [7:0] w_rx_byte;
  logic       w_rx_valid;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (w_rx_byte),
    .byte_valid (w_rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  logic       r_ext_pend, r_brk_pend;
  logic       w_is_ext, w_is_brk, w_evt_formed, w_suppress, w_evt_go;
  key_event_t w_evt;

  assign w_is_ext     = w_rx_valid && (w_rx_byte == SC_EXT);
  assign w_is_brk     = w_rx_valid && (w_rx_byte == SC_BREAK);
  assign w_evt_formed = w_rx_valid && !w_is_ext && !w_is_brk;
  assign w_evt.code   = w_rx_byte;
  assign w_evt.ext    = r_ext_pend;
  assign w_evt.brk    = r_brk_pend;
  assign w_evt_go     = w_evt_formed && !w_suppress;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_evt_formed) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else begin
      if (w_is_ext) r_ext_pend <= 1'b1;
      if (w_is_brk) r_brk_pend <= 1'b1;
    end
  end

`ifdef PS2_KEYSCAN_TYPEMATIC_FILTER_EN
  logic [8:0] r_last_make;
  logic       r_last_vld;

  assign w_suppress = w_evt_formed && !w_evt.brk && r_last_vld &&
                      (r_last_make == {w_evt.code, w_evt.ext});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_make <= '0;
      r_last_vld  <= 1'b0;
    end else if (w_evt_formed) begin
      if (w_evt.brk) begin
        r_last_vld <= 1'b0;
      end else begin
        r_last_vld  <= 1'b1;
        r_last_make <= {w_evt.code, w_evt.ext};
      end
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  dir_t r_dir, w_dir_nxt, w_key_dir;

  assign w_key_dir = wasd_dir(w_evt.code);

  always_comb begin
    w_dir_nxt = r_dir;
    if (w_evt_go && !w_evt.ext && w_key_dir != DIR_NONE) begin
      if (!w_evt.brk)              w_dir_nxt = w_key_dir;
      else if (r_dir == w_key_dir) w_dir_nxt = DIR_NONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_dir <= DIR_NONE;
    else          r_dir <= w_dir_nxt;
  end

  assign dir = r_dir;

  key_event_t    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          w_full, w_pop, w_push;
  key_event_t    w_head;

  assign w_full = (r_count == c_DEPTH);
  assign w_pop  = key_valid && key_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_push = w_evt_go && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_evt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= w_evt_go && w_full && !w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign key_valid = (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign key_code  = key_valid ? w_head.code : 8'h00;
  assign key_ext   = key_valid & w_head.ext;
  assign key_break = key_valid & w_head.brk;
  assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyscan.sv
// ============================================================
// Module  : tb_ps2_keyscan
// Brief   : Self-checking bench: byte-sequence table plus error, overflow,
//           typematic (PS2_KEYSCAN_TYPEMATIC_FILTER_EN) and reset sequences.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

module tb_ps2_keyscan;
  import ps2_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 300;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b1;
  logic       key_valid, key_ext, key_break;
  logic       parity_err, frame_err, overflow;
  logic [7:0] key_code;
  logic [2:0] dir;

  always #5 clk = ~clk;

  ps2_keyscan #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .dir        (dir),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  int errors = 0;
  int checks = 0;
  key_event_t exp_q[$];

  // Observer: records popped events and counts pulse cycles
  key_event_t obs [256];
  int obs_wr = 0, pe_cnt = 0, fe_cnt = 0, ov_cnt = 0, vcyc = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (key_valid) vcyc++;
      if (parity_err) pe_cnt++;
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
      if (key_valid && key_ready) begin
        obs[obs_wr % 256] = '{code: key_code, ext: key_ext, brk: key_break};
        obs_wr++;
      end
    end
  end

  int obs_rd = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_bit, input int nbits);
    logic [10:0] f;
    f = {stop_bit, (~(^b)) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back('{code: code, ext: ext, brk: brk});
  endtask

  task automatic check_events(input string name);
    key_event_t e, o;
    int t;
    t = 0;
    repeat (6) @(negedge clk);
    while (exp_q.size() != 0 && t < 200) begin
      if (obs_rd < obs_wr) begin
        e = exp_q.pop_front();
        o = obs[obs_rd % 256];
        obs_rd++;
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL %s event: got code=%0h ext=%0b brk=%0b, expected code=%0h ext=%0b brk=%0b",
                   name, o.code, o.ext, o.brk, e.code, e.ext, e.brk);
        end
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s missing: got %0d events short, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    while (obs_rd < obs_wr) begin
      o = obs[obs_rd % 256];
      obs_rd++;
      checks++;
      errors++;
      $display("FAIL %s unexpected: got code=%0h ext=%0b brk=%0b, expected none",
               name, o.code, o.ext, o.brk);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       evt;
    logic       ext;
    logic       brk;
    logic [2:0] dir;
  } vec_t;

  vec_t tbl [19];
  int   pe0, fe0, ov0, vc0;

  initial begin
    tbl[0]  = '{8'h1D, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 3'd3};
    tbl[2]  = '{8'h1D, 1'b1, 1'b0, 1'b1, 3'd0};
    tbl[3]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[5]  = '{8'h1D, 1'b1, 1'b0, 1'b1, 3'd1};
    tbl[6]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[7]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[8]  = '{8'h75, 1'b1, 1'b1, 1'b1, 3'd1};
    tbl[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[10] = '{8'h1D, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[11] = '{8'h23, 1'b1, 1'b0, 1'b0, 3'd2};
    tbl[12] = '{8'hF0, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[13] = '{8'h1C, 1'b1, 1'b0, 1'b1, 3'd2};
    tbl[14] = '{8'hF0, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[15] = '{8'h23, 1'b1, 1'b0, 1'b1, 3'd0};
    tbl[16] = '{8'h1B, 1'b1, 1'b0, 1'b0, 3'd4};
    tbl[17] = '{8'hF0, 1'b0, 1'b0, 1'b0, 3'd4};
    tbl[18] = '{8'h1B, 1'b1, 1'b0, 1'b1, 3'd0};

    repeat (4) @(negedge clk);
    chk("reset key_valid", int'(key_valid), 0);
    chk("reset key_code", int'(key_code), 0);
    chk("reset key_ext", int'(key_ext), 0);
    chk("reset key_break", int'(key_break), 0);
    chk("reset dir", int'(dir), 0);
    chk("reset parity_err", int'(parity_err), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset overflow", int'(overflow), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].evt) push_exp(tbl[i].b, tbl[i].ext, tbl[i].brk);
      send_frame(tbl[i].b, 1'b0, 1'b1, 11);
      check_events("table");
      chk("table dir", int'(dir), int'(tbl[i].dir));
      if (i == 0) chk("single-cycle key_valid", vcyc, 1);
    end

    // Pending E0 must survive the rejected frames below
    send_frame(8'hE0, 1'b0, 1'b1, 11);
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h23, 1'b1, 1'b1, 11);
    repeat (6) @(negedge clk);
    chk("parity_err pulse", pe_cnt - pe0, 1);
    chk("parity no frame_err", fe_cnt - fe0, 0);
    check_events("parity");
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    repeat (6) @(negedge clk);
    chk("stop frame_err pulse", fe_cnt - fe0, 1);
    check_events("stop");
    send_frame(8'h00, 1'b0, 1'b1, 5);
    repeat (TO + 40) @(negedge clk);
    chk("timeout frame_err pulse", fe_cnt - fe0, 2);
    chk("errors keep dir", int'(dir), 0);
    push_exp(8'h75, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 11);
    check_events("after errors");
    push_exp(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_events("recover");
    chk("recover dir", int'(dir), 1);

    push_exp(8'h1B, 1'b0, 1'b0);
`ifndef PS2_KEYSCAN_TYPEMATIC_FILTER_EN
    push_exp(8'h1B, 1'b0, 1'b0);
    push_exp(8'h1B, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 3; i++) send_frame(8'h1B, 1'b0, 1'b1, 11);
    check_events("typematic");
    chk("typematic dir", int'(dir), 4);

    key_ready = 1'b0;
    ov0 = ov_cnt;
    push_exp(8'h15, 1'b0, 1'b0);
    push_exp(8'h16, 1'b0, 1'b0);
    push_exp(8'h1E, 1'b0, 1'b0);
    push_exp(8'h26, 1'b0, 1'b0);
    send_frame(8'h15, 1'b0, 1'b1, 11);
    send_frame(8'h16, 1'b0, 1'b1, 11);
    send_frame(8'h1E, 1'b0, 1'b1, 11);
    send_frame(8'h26, 1'b0, 1'b1, 11);
    send_frame(8'h25, 1'b0, 1'b1, 11);
    repeat (6) @(negedge clk);
    chk("overflow pulse", ov_cnt - ov0, 1);
    chk("full key_valid", int'(key_valid), 1);
    chk("full head code", int'(key_code), 8'h15);
    key_ready = 1'b1;
    check_events("overflow drain");
    chk("drained key_valid", int'(key_valid), 0);
    chk("overflow dir", int'(dir), 4);

    key_ready = 1'b0;
    send_frame(8'h1D, 1'b0, 1'b1, 11);
    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 6);
    chk("pre-reset key_valid", int'(key_valid), 1);
    chk("pre-reset dir", int'(dir), 3);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid-reset key_valid", int'(key_valid), 0);
    chk("mid-reset key_code", int'(key_code), 0);
    chk("mid-reset dir", int'(dir), 0);
    chk("mid-reset frame_err", int'(frame_err), 0);
    reset_n = 1'b1;
    key_ready = 1'b1;
    repeat (TO + 40) @(negedge clk);
    chk("post-reset key_valid", int'(key_valid), 0);
    push_exp(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_events("post-reset");
    chk("post-reset dir", int'(dir), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_keyscan.md
# ps2_keyscan

Parametrised PS/2 keyboard receiver and key-event decoder running on the system clock. It oversamples the keyboard's clock and data lines, deserialises and parity-checks Set-2 scan-code frames, and assembles make/break/extended prefixes into complete key events. Events are queued in a small FIFO with a valid/ready pop interface, and the block also presents a held WASD direction code to downstream game/motion logic.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk/ps2_data; ≥2.
- TIMEOUT_CYCLES, 50000: system clocks with no PS/2 falling edge before an open frame is aborted.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw keyboard clock, asynchronous to clock.
- ps2_data  in  1  raw keyboard data, asynchronous to clock.
- key_valid  out  1  FIFO non-empty; head event is on key_code/key_ext/key_break.
- key_ready  in  1  consumer pops the head when key_valid && key_ready.
- key_code  out  8  head event scan code (prefix bytes stripped).
- key_ext  out  1  head event was preceded by E0.
- key_break  out  1  head event was preceded by F0 (key release).
- dir  out  3  held direction: 0 none, 1 A, 2 D, 3 W, 4 S.
- parity_err  out  1  one-cycle pulse: frame rejected on parity.
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  one-cycle pulse: completed event dropped, FIFO full.

## Operation
- Both PS/2 inputs pass through SYNC_STAGES flops; a falling edge is synced clk 1 → 0 between consecutive cycles. Data is sampled from the synced line on that cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data 0 (start bit), go to DATA with the bit counter at 0. An edge with data 1 is ignored.
  - DATA: 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on the edge, if stop = 1 and XOR(data, parity) = 1 (odd parity), emit the byte; otherwise pulse the matching error. Return to IDLE in every case.
- Timeout: in any state except IDLE, a counter runs and clears on each edge. When it reaches TIMEOUT_CYCLES, pulse frame_err, return to IDLE, and discard the partial byte.
- Event composer, per good byte:
  - E0 sets the pending ext flag.
  - F0 sets the pending brk flag.
  - Any other byte forms the event {code, ext, brk}, attempts a push, and clears both flags.
  - E0 and F0 never reach the FIFO. Flags survive framing errors but clear on reset.
- FIFO: show-ahead. The head is visible while key_valid is high.
  - Pop when empty: no effect.
  - Push when full without a same-cycle pop: the event is dropped and overflow pulses.
  - Push and pop in the same cycle when full: both occur and the count is unchanged.
- dir is updated only by non-extended WASD events (1C=A, 23=D, 1D=W, 1B=S), and only when the event is produced, independent of FIFO space.
  - Make sets dir to that key's code.
  - Break of the key currently in dir sets dir to 0.
  - Break of any other key leaves dir unchanged.
  - Extended and non-WASD events never change dir.

## Timing
- Reset values: key_valid 0, key_code 0, key_ext 0, key_break 0, dir 0, all error pulses 0, FSM IDLE, FIFO empty, flags clear. Reset asserted mid-frame discards everything immediately.
- Input latency: SYNC_STAGES + 1 clocks from raw ps2_clk fall to the edge-detect cycle.
- Stop-bit edge-detect cycle N:
  - Composer registers the byte at N+1.
  - FIFO write and dir update at N+2.
  - key_valid visible at N+2 if the FIFO was empty.
- Error pulses assert at N+1 and last exactly one cycle.
- Pop takes effect at the clock edge where key_valid && key_ready; the next head (or key_valid 0) appears in the following cycle.

## Configuration
- PS2_KEYSCAN_TYPEMATIC_FILTER_EN defined:
  - A make event whose {code, ext} equals the last make with no intervening break of that key is suppressed. It is not pushed and does not change dir.
  - Any break clears the last-make register.
- Undefined: every make, including typematic repeats, is pushed.

## Structure
- Package ps2_pkg holds:
  - dir_t enum (DIR_NONE=0, DIR_A=1, DIR_D=2, DIR_W=3, DIR_S=4).
  - key_event_t struct {code[7:0], ext, brk}.
  - Constants SC_W=8'h1D, SC_A=8'h1C, SC_S=8'h1B, SC_D=8'h23, SC_BREAK=8'hF0, SC_EXT=8'hE0.
- Sub-module ps2_frame_rx contains the synchroniser, edge detect, frame FSM, parity check and timeout. It outputs byte/byte_valid/parity_err/frame_err.
- The composer, FIFO and dir tracking live in ps2_keyscan.

## Test plan
- Frame 1D with correct parity, key_ready 1 -> key_valid for one cycle with key_code 1D, ext 0, break 0; dir = 3.
- Bytes F0, 1D after W held -> one event {1D, brk=1}; dir = 0. Then 1C -> dir = 1, and a later F0, 1D leaves dir = 1.
- Bytes E0, F0, 75 -> single event {75, ext=1, brk=1}; dir unchanged.
- Frame 23 with flipped parity bit -> parity_err pulse, no event. Stop bit 0 -> frame_err pulse. ps2_clk stalled after 4 bits for TIMEOUT_CYCLES -> frame_err, then the next good frame decodes correctly.
- key_ready 0, FIFO_DEPTH+1 distinct makes -> FIFO_DEPTH events retained in order, overflow pulses once, last event lost.
- Three repeated 1B makes -> 3 events without the macro, 1 event with PS2_KEYSCAN_TYPEMATIC_FILTER_EN. Reset asserted mid-frame -> all outputs return to reset values.
